// File: rtl/led_src_sched.sv
// LED source scheduler: picks RP0..RP2 or the block-design LED, blanking GAP cycles on every switch.
// Latency: led_o is one registered stage behind the selected source; a switch lands GAP+1 cycles after its decision.
// Backpressure: none; all inputs are sampled every cycle and edges seen during a switch are dropped.
module led_src_sched #(
    parameter int DWELL_W = 32,
    parameter int GAP     = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk100,
    input  logic               rstn,
    input  logic [2:0]         led_in,
    input  logic               bd_led,
    input  logic [2:0]         int_vec,
    input  logic [1:0]         mode,
    input  logic [1:0]         sel_cfg,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               dfx_active,
    input  logic [1:0]         dfx_rp,
    output logic               led_o,
    output logic [1:0]         led_sel,
    output logic               dfx_ack,
    output logic               sw_pulse,
    output logic [CNT_W-1:0]   switch_cnt
);

    typedef enum logic {RUN, SWITCH} state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    state_t             st;
    logic [1:0]         target;
    logic [1:0]         rp_lat;
    logic [7:0]         gap_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [2:0]         int_q;
    logic               dfx_q;

    logic [3:0]         elig;
    logic [3:0]         src_vec;
    logic [2:0]         int_rise;
    logic [DWELL_W-1:0] dwell_m1;
    logic [1:0]         tgt;
    logic [1:0]         nxt_sel;
    logic               go_switch;
    logic               gap_done;
    logic               commit;
    logic               nxt_run;

    // First eligible source after src in the ring 0,1,2,3; source 3 is always a valid fallback.
    function automatic logic [1:0] next_after(input logic [1:0] src, input logic [3:0] ok);
        logic [1:0] c;
        next_after = 2'd3;
        for (int k = 3; k >= 1; k--) begin
            c = src + 2'(k);
            if (ok[c]) next_after = c;
        end
    endfunction

    always_comb begin
        elig = 4'b1111;
        if (dfx_q) elig[rp_lat] = 1'b0;
        elig[3] = 1'b1;

        src_vec  = {bd_led, led_in};
        int_rise = int_vec & ~int_q;
        dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

        tgt = led_sel;
        if (!elig[led_sel]) begin
            tgt = next_after(led_sel, elig);
        end else begin
            case (mode)
                2'd0: tgt = elig[sel_cfg] ? sel_cfg : 2'd3;
                2'd1: if (dwell_cnt >= dwell_m1) tgt = next_after(led_sel, elig);
                2'd2: begin
                    if (int_rise[0] && elig[0])      tgt = 2'd0;
                    else if (int_rise[1] && elig[1]) tgt = 2'd1;
                    else if (int_rise[2] && elig[2]) tgt = 2'd2;
                end
                default: tgt = 2'd3;
            endcase
        end

        go_switch = (st == RUN) && (tgt != led_sel);
        gap_done  = (st == SWITCH) && (gap_cnt == GAP_LAST);
        commit    = gap_done && elig[target];
        nxt_sel   = commit ? target : led_sel;
        nxt_run   = ((st == RUN) && !go_switch) || commit;
    end

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            st         <= RUN;
            target     <= 2'd3;
            rp_lat     <= 2'd3;
            gap_cnt    <= '0;
            dwell_cnt  <= '0;
            int_q      <= '0;
            dfx_q      <= 1'b0;
            led_o      <= 1'b0;
            led_sel    <= 2'd3;
            dfx_ack    <= 1'b0;
            sw_pulse   <= 1'b0;
            switch_cnt <= '0;
        end else begin
            int_q    <= int_vec;
            dfx_q    <= dfx_active;
            if (dfx_active && !dfx_q) rp_lat <= dfx_rp;
            sw_pulse <= commit;
            // Ack looks at the post-edge selection so it rises together with the RUN entry.
            dfx_ack  <= dfx_active && dfx_q && nxt_run && (nxt_sel != rp_lat);
            led_o    <= ((st == RUN) && !go_switch) ? src_vec[led_sel] : 1'b0;

            case (st)
                RUN: begin
                    if (go_switch) begin
                        st      <= SWITCH;
                        target  <= tgt;
                        gap_cnt <= '0;
                    end else if (dwell_cnt != '1) begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end
                default: begin
                    if (gap_done) begin
                        if (elig[target]) begin
                            led_sel    <= target;
                            st         <= RUN;
                            switch_cnt <= switch_cnt + CNT_W'(1);
                            dwell_cnt  <= '0;
                        end else begin
                            target  <= next_after(target, elig);
                            gap_cnt <= '0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_src_sched.sv
// Bench for led_src_sched: directed scenarios plus random traffic, every cycle compared to a behavioural model.
module tb_led_src_sched;

    localparam int GAP   = 4;
    localparam int CNT_W = 6;

    logic        clk100 = 1'b0;
    logic        rstn;
    logic [2:0]  led_in;
    logic        bd_led;
    logic [2:0]  int_vec;
    logic [1:0]  mode;
    logic [1:0]  sel_cfg;
    logic [31:0] dwell;
    logic        dfx_active;
    logic [1:0]  dfx_rp;
    logic        led_o;
    logic [1:0]  led_sel;
    logic        dfx_ack;
    logic        sw_pulse;
    logic [CNT_W-1:0] switch_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [2:0] samp_led_in;

    // Reference model state, kept as plain integers.
    int         m_run, m_sel, m_tgt, m_left, m_rp, m_dfxq;
    longint     m_dwell;
    logic [2:0] m_intq;
    int         m_led, m_ack, m_pulse, m_cnt;

    led_src_sched #(.DWELL_W(32), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk100(clk100), .rstn(rstn), .led_in(led_in), .bd_led(bd_led),
        .int_vec(int_vec), .mode(mode), .sel_cfg(sel_cfg), .dwell(dwell),
        .dfx_active(dfx_active), .dfx_rp(dfx_rp), .led_o(led_o), .led_sel(led_sel),
        .dfx_ack(dfx_ack), .sw_pulse(sw_pulse), .switch_cnt(switch_cnt)
    );

    always #5 clk100 = ~clk100;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_elig(input int s);
        return (s == 3) || !(m_dfxq != 0 && m_rp == s);
    endfunction

    function automatic int m_next(input int s);
        for (int k = 1; k <= 4; k++)
            if (m_elig((s + k) % 4)) return (s + k) % 4;
        return 3;
    endfunction

    task automatic model_reset();
        m_run = 1; m_sel = 3; m_tgt = 3; m_left = 0; m_dwell = 0;
        m_intq = 3'b000; m_dfxq = 0; m_rp = 3;
        m_led = 0; m_ack = 0; m_pulse = 0; m_cnt = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int tgt, dw;
        int led_n;
        led_n   = 0;
        m_pulse = 0;
        if (m_run != 0) begin
            dw  = (dwell == 0) ? 1 : int'(dwell);
            tgt = m_sel;
            if (!m_elig(m_sel))
                tgt = m_next(m_sel);
            else if (mode == 2'd0)
                tgt = m_elig(int'(sel_cfg)) ? int'(sel_cfg) : 3;
            else if (mode == 2'd1) begin
                if (m_dwell + 1 >= dw) tgt = m_next(m_sel);
            end else if (mode == 2'd2) begin
                for (int i = 2; i >= 0; i--)
                    if (int_vec[i] && !m_intq[i] && m_elig(i)) tgt = i;
            end else
                tgt = 3;
            if (tgt != m_sel) begin
                m_run = 0; m_tgt = tgt; m_left = GAP;
            end else begin
                m_dwell++;
                led_n = (m_sel == 3) ? int'(bd_led) : int'(led_in[m_sel]);
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_elig(m_tgt)) begin
                    m_sel = m_tgt; m_run = 1; m_dwell = 0; m_pulse = 1;
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                end else begin
                    m_tgt  = m_next(m_tgt);
                    m_left = GAP;
                end
            end
        end
        m_ack = (dfx_active && m_dfxq != 0 && m_run != 0 && m_sel != m_rp) ? 1 : 0;
        m_led = led_n;
        if (dfx_active && m_dfxq == 0) m_rp = int'(dfx_rp);
        m_dfxq = int'(dfx_active);
        m_intq = int_vec;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge after comparing outputs.
    task automatic cycle();
        led_in = 3'($urandom);
        bd_led = 1'($urandom);
        samp_led_in = led_in;
        if (!rstn) model_reset(); else model_step();
        @(posedge clk100);
        @(negedge clk100);
        cyc++;
        chk("led_o", led_o, m_led);
        chk("led_sel", led_sel, m_sel);
        chk("dfx_ack", dfx_ack, m_ack);
        chk("sw_pulse", sw_pulse, m_pulse);
        chk("switch_cnt", switch_cnt, m_cnt);
    endtask

    task automatic wait_sel(input logic [1:0] want);
        int n;
        n = 0;
        while (led_sel != want && n < 100) begin
            cycle();
            n++;
        end
        chk("wait_sel", led_sel, want);
    endtask

    initial begin
        int last_pulse, npulse, prev_sel, wrap_seen, cnt_before;
        rstn = 1'b0; led_in = '0; bd_led = 1'b0; int_vec = '0;
        mode = 2'd0; sel_cfg = 2'd1; dwell = 32'd10; dfx_active = 1'b0; dfx_rp = 2'd0;
        model_reset();
        @(negedge clk100);
        repeat (3) cycle();
        chk("rst_led_o", led_o, 0);
        chk("rst_led_sel", led_sel, 3);
        chk("rst_ack", dfx_ack, 0);
        chk("rst_cnt", switch_cnt, 0);

        // Release in mode 0 with sel_cfg=1.
        rstn = 1'b1;
        for (int c = 1; c <= GAP + 3; c++) begin
            cycle();
            chk("boot_sel", led_sel, (c >= GAP + 1) ? 1 : 3);
            if (c == GAP + 1) chk("boot_pulse", sw_pulse, 1);
            if (c == GAP + 2) chk("boot_led", led_o, samp_led_in[1]);
        end
        chk("boot_cnt", switch_cnt, 1);

        // Round robin, dwell 10: period 14, order 0,1,2,3, counter wrap.
        mode = 2'd1; dwell = 32'd10;
        npulse = 0; last_pulse = 0; prev_sel = led_sel; wrap_seen = 0;
        for (int n = 0; n < 1200 && npulse < 70; n++) begin
            cnt_before = switch_cnt;
            cycle();
            if (sw_pulse) begin
                chk("rr_order", led_sel, (prev_sel + 1) % 4);
                if (npulse > 0) chk("rr_period", cyc - last_pulse, 14);
                if (cnt_before == (1 << CNT_W) - 1) begin
                    chk("cnt_wrap", switch_cnt, 0);
                    wrap_seen = 1;
                end
                prev_sel = led_sel; last_pulse = cyc; npulse++;
            end
        end
        chk("rr_pulses", npulse, 70);
        chk("rr_wrap_seen", wrap_seen, 1);

        // Interrupt-driven: simultaneous edges on 1 and 2 pick 1; edge during the gap is dropped.
        mode = 2'd0; sel_cfg = 2'd0;
        wait_sel(2'd0);
        mode = 2'd2; int_vec = 3'b000; cycle();
        int_vec = 3'b110; cycle();
        int_vec = 3'b000; cycle();
        int_vec = 3'b100; cycle();
        int_vec = 3'b000;
        npulse = 0;
        for (int n = 0; n < GAP + 8; n++) begin
            cycle();
            if (sw_pulse) npulse++;
        end
        chk("int_sel", led_sel, 1);
        chk("int_pulses", npulse, 1);

        // DFX on the selected partition, then release.
        mode = 2'd0; sel_cfg = 2'd2;
        wait_sel(2'd2);
        cycle();
        dfx_rp = 2'd2; dfx_active = 1'b1;
        for (int j = 1; j <= GAP + 3; j++) begin
            cycle();
            chk("dfx_ack_rise", dfx_ack, (j >= GAP + 2) ? 1 : 0);
            chk("dfx_sel", led_sel, (j >= GAP + 2) ? 3 : 2);
        end
        dfx_rp = 2'd0;
        cycle();
        chk("dfx_rp_ignored", dfx_ack, 1);
        dfx_active = 1'b0;
        for (int j = 1; j <= GAP + 3; j++) begin
            cycle();
            chk("dfx_ack_fall", dfx_ack, 0);
            chk("dfx_return", led_sel, (j >= GAP + 2) ? 2 : 3);
        end

        // DFX hits the target partition mid-gap: land on 2 with one pulse.
        sel_cfg = 2'd0;
        wait_sel(2'd0);
        mode = 2'd2; int_vec = 3'b000; cycle();
        int_vec = 3'b010; cycle();
        int_vec = 3'b000; cycle();
        dfx_rp = 2'd1; dfx_active = 1'b1; cycle();
        npulse = 0;
        for (int n = 0; n < 2 * GAP + 4; n++) begin
            cycle();
            if (sw_pulse) npulse++;
        end
        chk("mid_gap_sel", led_sel, 2);
        chk("mid_gap_pulses", npulse, 1);
        chk("mid_gap_ack", dfx_ack, 1);
        dfx_active = 1'b0;
        repeat (3) cycle();

        // Asynchronous reset in the middle of a switch.
        mode = 2'd3;
        repeat (3) cycle();
        #2 rstn = 1'b0;
        #1;
        chk("arst_led_o", led_o, 0);
        chk("arst_led_sel", led_sel, 3);
        chk("arst_cnt", switch_cnt, 0);
        chk("arst_ack", dfx_ack, 0);
        model_reset();
        @(negedge clk100);
        cycle();
        rstn = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 19) == 0) sel_cfg = 2'($urandom);
            if ($urandom_range(0, 49) == 0) dwell = 32'($urandom_range(0, 5));
            int_vec = 3'($urandom) & 3'($urandom) & 3'($urandom);
            if ($urandom_range(0, 29) == 0) dfx_active = ~dfx_active;
            dfx_rp = 2'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
